// File: rtl/fetch_unit.sv
// Program counter and fetch stage feeding the instruction ROM; captures ROM data
// into the instruction register and handles start/halt, stall and jump squash.
module fetch_unit #(
    parameter int             D          = 12,
    parameter logic [D-1:0]   START_ADDR = '0,
    parameter logic [8:0]     HALT_CODE  = 9'b111111111
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic [8:0]          mach_code,
    input  logic                jump_en,
    input  logic                jump_rel,
    input  logic [D-1:0]        jump_target,
    input  logic signed [7:0]   jump_offset,
    output logic [D-1:0]        prog_ctr,
    output logic [8:0]          instr,
    output logic [D-1:0]        instr_pc,
    output logic                instr_valid,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [D-1:0] PC_ONE = {{(D-1){1'b0}}, 1'b1};

    state_t       state, state_nxt;
    logic [D-1:0] pc_nxt, ipc_nxt;
    logic [8:0]   instr_nxt;
    logic         vld_nxt;

    // Relative target wraps modulo 2**D; the offset is sign-extended first.
    function automatic logic [D-1:0] rel_target(input logic [D-1:0] base,
                                                input logic signed [7:0] off);
        logic signed [D:0] off_ext;
        logic signed [D:0] sum;
        off_ext = $signed({{(D-7){off[7]}}, off});
        sum     = $signed({1'b0, base}) + off_ext;
        return sum[D-1:0];
    endfunction

    always_comb begin
        state_nxt = state;
        pc_nxt    = prog_ctr;
        instr_nxt = instr;
        ipc_nxt   = instr_pc;
        vld_nxt   = instr_valid;
        case (state)
            IDLE: begin
                vld_nxt = 1'b0;
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_ADDR;
                end
            end
            RUN: begin
                if (start) begin
                    pc_nxt  = START_ADDR;
                    vld_nxt = 1'b0;
                end else if (!stall) begin
                    if (jump_en && instr_valid) begin
                        // The word on mach_code is wrong-path; drop it without halt detection.
                        pc_nxt  = jump_rel ? rel_target(instr_pc, jump_offset) : jump_target;
                        vld_nxt = 1'b0;
                    end else begin
                        instr_nxt = mach_code;
                        ipc_nxt   = prog_ctr;
                        vld_nxt   = 1'b1;
                        if (mach_code == HALT_CODE) begin
                            state_nxt = HALT;
                        end else begin
                            pc_nxt = prog_ctr + PC_ONE;
                        end
                    end
                end
            end
            HALT: begin
                vld_nxt = 1'b0;
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_ADDR;
                end
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    // Fetch register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            prog_ctr    <= START_ADDR;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            prog_ctr    <= pc_nxt;
            instr       <= instr_nxt;
            instr_pc    <= ipc_nxt;
            instr_valid <= vld_nxt;
        end
    end

    assign done = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the main sequences plus
// hand-written halt / squash / mid-run reset sequences, against a modelled ROM.
module tb_fetch_unit;

    logic              clk = 1'b0;
    logic              reset, start, stall, jump_en, jump_rel;
    logic [11:0]       jump_target;
    logic signed [7:0] jump_offset;
    logic [8:0]        mach_code;
    logic [11:0]       prog_ctr, instr_pc;
    logic [8:0]        instr;
    logic              instr_valid, done;

    logic [8:0] rom [0:4095];

    int n_tests = 0;
    int n_fail  = 0;
    int step    = 0;

    typedef struct {
        logic        rst, st, stl, jen, jrel;
        logic [11:0] tgt;
        logic [7:0]  off;
        logic [11:0] pc;
        logic [8:0]  ins;
        logic [11:0] ipc;
        logic        iv, dn, ci;
    } vec_t;

    vec_t tbl[$];

    fetch_unit #(.D(12), .START_ADDR(12'h000), .HALT_CODE(9'h1FF)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .mach_code(mach_code), .jump_en(jump_en), .jump_rel(jump_rel),
        .jump_target(jump_target), .jump_offset(jump_offset),
        .prog_ctr(prog_ctr), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .done(done)
    );

    always #5 clk = ~clk;
    always_comb mach_code = rom[prog_ctr];

    function automatic vec_t mk(input logic rst, st, stl, jen, jrel,
                                input logic [11:0] tgt, input logic [7:0] off,
                                input logic [11:0] pc, input logic [8:0] ins,
                                input logic [11:0] ipc, input logic iv, dn, ci);
        vec_t v;
        v.rst = rst; v.st = st; v.stl = stl; v.jen = jen; v.jrel = jrel;
        v.tgt = tgt; v.off = off; v.pc = pc; v.ins = ins; v.ipc = ipc;
        v.iv = iv; v.dn = dn; v.ci = ci;
        return v;
    endfunction

    // Plain sequential fetch with no control inputs asserted.
    function automatic vec_t run(input logic [11:0] pc, input logic [8:0] ins,
                                 input logic [11:0] ipc);
        return mk(0, 0, 0, 0, 0, 12'h0, 8'h0, pc, ins, ipc, 1, 0, 1);
    endfunction

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL step%0d %s got %h want %h", step, nm, got, want);
        end
    endtask

    task automatic cyc(input vec_t v);
        reset = v.rst; start = v.st; stall = v.stl; jump_en = v.jen;
        jump_rel = v.jrel; jump_target = v.tgt; jump_offset = v.off;
        @(posedge clk);
        #1;
        step++;
        chk("prog_ctr", prog_ctr, v.pc);
        chk("instr_valid", {11'h0, instr_valid}, {11'h0, v.iv});
        chk("done", {11'h0, done}, {11'h0, v.dn});
        if (v.ci) begin
            chk("instr", {3'h0, instr}, {3'h0, v.ins});
            chk("instr_pc", instr_pc, v.ipc);
        end
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) rom[k] = k[8:0];
        rom[12'hFFF] = 9'h0AA;
        reset = 1'b0; start = 1'b0; stall = 1'b0; jump_en = 1'b0;
        jump_rel = 1'b0; jump_target = '0; jump_offset = '0;

        // reset, idle ignoring stall/jump, start and sequential fetch
        tbl.push_back(mk(1, 0, 0, 0, 0, 12'h0,   8'h0, 12'h000, 9'h000, 12'h000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 12'h100, 8'h0, 12'h000, 9'h000, 12'h000, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 12'h0,   8'h0, 12'h000, 9'h000, 12'h000, 0, 0, 1));
        tbl.push_back(run(12'h001, 9'h000, 12'h000));
        tbl.push_back(run(12'h002, 9'h001, 12'h001));
        tbl.push_back(run(12'h003, 9'h002, 12'h002));
        tbl.push_back(run(12'h004, 9'h003, 12'h003));
        // stall 3 cycles at prog_ctr=4, with a jump request ignored meanwhile
        tbl.push_back(mk(0, 0, 1, 0, 0, 12'h0,   8'h0, 12'h004, 9'h003, 12'h003, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 12'h100, 8'h0, 12'h004, 9'h003, 12'h003, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 12'h0,   8'h0, 12'h004, 9'h003, 12'h003, 1, 0, 1));
        tbl.push_back(run(12'h005, 9'h004, 12'h004));
        tbl.push_back(run(12'h006, 9'h005, 12'h005));
        // start in RUN beats stall and jump
        tbl.push_back(mk(0, 1, 1, 1, 0, 12'h100, 8'h0, 12'h000, 9'h000, 12'h000, 0, 0, 0));
        tbl.push_back(run(12'h001, 9'h000, 12'h000));
        tbl.push_back(run(12'h002, 9'h001, 12'h001));
        tbl.push_back(run(12'h003, 9'h002, 12'h002));
        tbl.push_back(run(12'h004, 9'h003, 12'h003));
        // absolute jump at instr_pc=3
        tbl.push_back(mk(0, 0, 0, 1, 0, 12'h100, 8'h0, 12'h100, 9'h000, 12'h000, 0, 0, 0));
        tbl.push_back(run(12'h101, 9'h100, 12'h100));
        tbl.push_back(run(12'h102, 9'h101, 12'h101));
        // restart; jump with instr_valid=0 is ignored; relative jump -3 at instr_pc=1
        tbl.push_back(mk(0, 1, 0, 0, 0, 12'h0,   8'h0, 12'h000, 9'h000, 12'h000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 12'h200, 8'h0, 12'h001, 9'h000, 12'h000, 1, 0, 1));
        tbl.push_back(run(12'h002, 9'h001, 12'h001));
        tbl.push_back(mk(0, 0, 0, 1, 1, 12'h0,   8'hFD, 12'hFFE, 9'h000, 12'h000, 0, 0, 0));
        tbl.push_back(run(12'hFFF, 9'h1FE, 12'hFFE));
        tbl.push_back(run(12'h000, 9'h0AA, 12'hFFF));
        tbl.push_back(run(12'h001, 9'h000, 12'h000));

        foreach (tbl[i]) cyc(tbl[i]);

        // HALT_CODE at address 6
        rom[6] = 9'h1FF;
        cyc(mk(1, 0, 0, 0, 0, 12'h0, 8'h0, 12'h000, 9'h000, 12'h000, 0, 0, 1));
        cyc(mk(0, 1, 0, 0, 0, 12'h0, 8'h0, 12'h000, 9'h000, 12'h000, 0, 0, 1));
        for (int k = 1; k <= 6; k++) cyc(run(12'(k), 9'(k - 1), 12'(k - 1)));
        cyc(mk(0, 0, 0, 0, 0, 12'h0,   8'h0, 12'h006, 9'h1FF, 12'h006, 1, 1, 1));
        cyc(mk(0, 0, 1, 1, 0, 12'h100, 8'h0, 12'h006, 9'h1FF, 12'h006, 0, 1, 1));
        cyc(mk(0, 0, 0, 0, 0, 12'h0,   8'h0, 12'h006, 9'h1FF, 12'h006, 0, 1, 1));
        // start from HALT
        cyc(mk(0, 1, 0, 0, 0, 12'h0,   8'h0, 12'h000, 9'h000, 12'h000, 0, 0, 0));
        // HALT_CODE in the squashed slot of a jump must not halt
        for (int k = 1; k <= 6; k++) cyc(run(12'(k), 9'(k - 1), 12'(k - 1)));
        cyc(mk(0, 0, 0, 1, 0, 12'h010, 8'h0, 12'h010, 9'h000, 12'h000, 0, 0, 0));
        cyc(run(12'h011, 9'h010, 12'h010));
        cyc(run(12'h012, 9'h011, 12'h011));

        // reset mid-run at prog_ctr=9, asserted together with start
        rom[6] = 9'h006;
        cyc(mk(0, 1, 0, 0, 0, 12'h0, 8'h0, 12'h000, 9'h000, 12'h000, 0, 0, 0));
        for (int k = 1; k <= 9; k++) cyc(run(12'(k), 9'(k - 1), 12'(k - 1)));
        cyc(mk(1, 1, 0, 0, 0, 12'h0, 8'h0, 12'h000, 9'h000, 12'h000, 0, 0, 1));
        cyc(mk(0, 0, 0, 0, 0, 12'h0, 8'h0, 12'h000, 9'h000, 12'h000, 0, 0, 1));
        cyc(mk(0, 0, 0, 0, 0, 12'h0, 8'h0, 12'h000, 9'h000, 12'h000, 0, 0, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
